// File: rtl/hit_flash_if.sv
// Handshake bundle between the frame timing / game logic and the flash
// controller: frame and trigger pulses in, flash enable and status out.
interface hit_flash_if;
  logic startOfFrame;
  logic trigger;
  logic flashEnable;
  logic busy;
  logic done;

  modport master (
    output startOfFrame,
    output trigger,
    input  flashEnable,
    input  busy,
    input  done
  );

  modport slave (
    input  startOfFrame,
    input  trigger,
    output flashEnable,
    output busy,
    output done
  );
endinterface

// File: rtl/hit_flash_ctrl.sv
// Hit flash controller: on a trigger, blinks flashEnable for BLINKS periods
// of FRAMES_ON frames high and FRAMES_OFF frames low, counted in
// startOfFrame pulses. A new trigger restarts the sequence; done pulses
// once when a sequence runs to completion.
module hit_flash_ctrl #(
  parameter int FRAMES_ON  = 4,
  parameter int FRAMES_OFF = 4,
  parameter int BLINKS     = 3
) (
  input  logic        clk,
  input  logic        resetN,
  hit_flash_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam logic [7:0] ON_LAST    = 8'(FRAMES_ON - 1);
  localparam logic [7:0] OFF_LAST   = 8'(FRAMES_OFF - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINKS - 1);

  state_t     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       flash_q, busy_q, done_q;
  logic       done_d;

  // Next-state, counter and completion logic; trigger overrides frame ticks.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    done_d      = 1'b0;
    if (bus.trigger) begin
      state_d     = ON;
      frame_cnt_d = 8'd0;
      blink_cnt_d = 8'd0;
    end else begin
      case (state_q)
        ON: begin
          if (bus.startOfFrame) begin
            if (frame_cnt_q == ON_LAST) begin
              state_d     = OFF;
              frame_cnt_d = 8'd0;
            end else begin
              frame_cnt_d = frame_cnt_q + 8'd1;
            end
          end
        end
        OFF: begin
          if (bus.startOfFrame) begin
            if (frame_cnt_q == OFF_LAST) begin
              frame_cnt_d = 8'd0;
              if (blink_cnt_q == BLINK_LAST) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end else begin
                state_d     = ON;
                blink_cnt_d = blink_cnt_q + 8'd1;
              end
            end else begin
              frame_cnt_d = frame_cnt_q + 8'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs; outputs track the next state so
  // they line up exactly with the cycles the state register holds it.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= IDLE;
      frame_cnt_q <= 8'd0;
      blink_cnt_q <= 8'd0;
      flash_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      flash_q     <= (state_d == ON);
      busy_q      <= (state_d == ON) || (state_d == OFF);
      done_q      <= done_d;
    end
  end

  assign bus.flashEnable = flash_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_hit_flash_ctrl.sv
// Bench for hit_flash_ctrl: a default instance and a 1/1/1 instance share
// stimulus; both are compared every cycle against a sequence-position model.
module tb_hit_flash_ctrl;

  logic clk = 1'b0;
  logic resetN;

  hit_flash_if bus_a ();
  hit_flash_if bus_b ();

  hit_flash_ctrl dut_a (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus_a.slave)
  );

  hit_flash_ctrl #(.FRAMES_ON(1), .FRAMES_OFF(1), .BLINKS(1)) dut_b (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus_b.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: a sequence is a position counted in frame pulses since the trigger.
  int m_on  [2] = '{4, 1};
  int m_off [2] = '{4, 1};
  int m_bl  [2] = '{3, 1};
  bit m_act [2];
  int m_pos [2];
  bit m_done[2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit trig, input bit sof, input bit rstn);
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (!rstn) begin
        m_act[i] = 1'b0;
        m_pos[i] = 0;
      end else if (trig) begin
        m_act[i] = 1'b1;
        m_pos[i] = 0;
      end else if (m_act[i] && sof) begin
        m_pos[i]++;
        if (m_pos[i] == m_bl[i] * (m_on[i] + m_off[i])) begin
          m_act[i]  = 1'b0;
          m_done[i] = 1'b1;
        end
      end
    end
  endtask

  function automatic bit m_flash(input int i);
    return m_act[i] && ((m_pos[i] % (m_on[i] + m_off[i])) < m_on[i]);
  endfunction

  // One clock: drive inputs, advance model at the edge, compare just after.
  task automatic step(input bit trig, input bit sof, input bit rstn);
    bus_a.trigger      = trig;
    bus_b.trigger      = trig;
    bus_a.startOfFrame = sof;
    bus_b.startOfFrame = sof;
    resetN             = rstn;
    @(posedge clk);
    model_edge(trig, sof, rstn);
    #1;
    check_eq("A.flashEnable", bus_a.flashEnable, m_flash(0));
    check_eq("A.busy",        bus_a.busy,        m_act[0]);
    check_eq("A.done",        bus_a.done,        m_done[0]);
    check_eq("B.flashEnable", bus_b.flashEnable, m_flash(1));
    check_eq("B.busy",        bus_b.busy,        m_act[1]);
    check_eq("B.done",        bus_b.done,        m_done[1]);
  endtask

  task automatic sofs(input int gap);
    repeat (gap - 1) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    int rises, dones, done_at, cnt;
    bit prev, got;

    bus_a.trigger = 1'b0; bus_a.startOfFrame = 1'b0;
    bus_b.trigger = 1'b0; bus_b.startOfFrame = 1'b0;
    resetN = 1'b0;

    // Reset state
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_eq("rst.flash", bus_a.flashEnable, 0);
    check_eq("rst.busy",  bus_a.busy, 0);
    check_eq("rst.done",  bus_a.done, 0);

    // Full default sequence, frame pulse every 10 cycles
    step(1'b1, 1'b0, 1'b1);
    check_eq("s27.rise_T1", bus_a.flashEnable, 1);
    rises = 1; prev = 1'b1; dones = 0; done_at = 0;
    for (int k = 1; k <= 24; k++) begin
      for (int g = 0; g < 10; g++) begin
        step(1'b0, g == 9, 1'b1);
        if (bus_a.flashEnable && !prev) rises++;
        prev = bus_a.flashEnable;
        if (bus_a.done) begin
          dones++;
          done_at = k;
          check_eq("s27.busy_at_done", bus_a.busy, 0);
        end
      end
      if (k == 3) check_eq("s27.high_sof3", bus_a.flashEnable, 1);
      if (k == 4) check_eq("s27.fall_sof4", bus_a.flashEnable, 0);
      if (k == 7) check_eq("s27.low_sof7", bus_a.flashEnable, 0);
      if (k == 8) check_eq("s27.rise_sof8", bus_a.flashEnable, 1);
    end
    repeat (20) begin
      step(1'b0, 1'b0, 1'b1);
      if (bus_a.done) dones++;
    end
    check_eq("s27.windows", rises, 3);
    check_eq("s27.done_count", dones, 1);
    check_eq("s27.done_after_sof", done_at, 24);

    // Retrigger during OFF phase of blink 2
    step(1'b1, 1'b0, 1'b1);
    repeat (14) sofs(3);
    check_eq("s28.off_blink2", bus_a.flashEnable, 0);
    check_eq("s28.busy_blink2", bus_a.busy, 1);
    step(1'b1, 1'b0, 1'b1);
    check_eq("s28.restart_flash", bus_a.flashEnable, 1);
    check_eq("s28.restart_nodone", bus_a.done, 0);
    cnt = 0; got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      sofs(3);
      if (bus_a.done) begin
        got = 1'b1;
        cnt = k;
      end
    end
    check_eq("s28.sofs_to_done", cnt, 24);

    // Trigger and frame pulse together, from IDLE
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check_eq("s29.idle_on", bus_a.flashEnable, 1);
    repeat (3) begin
      sofs(2);
      check_eq("s29.idle_stay_on", bus_a.flashEnable, 1);
    end
    sofs(2);
    check_eq("s29.idle_off4", bus_a.flashEnable, 0);

    // Trigger and frame pulse together, from ON with three frames counted
    step(1'b1, 1'b0, 1'b1);
    repeat (3) sofs(2);
    step(1'b1, 1'b1, 1'b1);
    check_eq("s29.on_flash", bus_a.flashEnable, 1);
    check_eq("s29.on_busy", bus_a.busy, 1);
    repeat (3) begin
      sofs(2);
      check_eq("s29.on_stay_on", bus_a.flashEnable, 1);
    end
    sofs(2);
    check_eq("s29.on_off4", bus_a.flashEnable, 0);

    // Reset during second ON phase
    step(1'b1, 1'b0, 1'b1);
    repeat (9) sofs(2);
    check_eq("s30.in_on2", bus_a.flashEnable, 1);
    step(1'b0, 1'b0, 1'b0);
    check_eq("s30.flash", bus_a.flashEnable, 0);
    check_eq("s30.busy",  bus_a.busy, 0);
    check_eq("s30.done",  bus_a.done, 0);
    repeat (10) begin
      sofs(2);
      check_eq("s30.quiet", {bus_a.flashEnable, bus_a.busy, bus_a.done}, 0);
    end

    // Minimal 1/1/1 instance
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check_eq("s31.flash_on", bus_b.flashEnable, 1);
    check_eq("s31.busy_on",  bus_b.busy, 1);
    sofs(3);
    check_eq("s31.flash_off", bus_b.flashEnable, 0);
    check_eq("s31.busy_off",  bus_b.busy, 1);
    check_eq("s31.nodone",    bus_b.done, 0);
    sofs(3);
    check_eq("s31.done",      bus_b.done, 1);
    check_eq("s31.busy_done", bus_b.busy, 0);

    // No trigger for 100 frames
    step(1'b0, 1'b0, 1'b0);
    repeat (100) begin
      sofs(2);
      check_eq("s32.quiet", {bus_a.flashEnable, bus_a.busy, bus_a.done}, 0);
    end

    // Randomized traffic, including held triggers and occasional resets
    repeat (3000) begin
      step(($urandom % 40) == 0, ($urandom % 4) == 0, ($urandom % 200) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
